// File: rtl/ama_riscv_mem_arbiter_pkg.sv
// rtl/ama_riscv_mem_arbiter_pkg.sv - shared types and defaults for the main-memory line-port arbiter
package ama_riscv_mem_arbiter_pkg;

  localparam int ARB_ADDR_W_DFLT = 32;
  localparam int ARB_LINE_W_DFLT = 512;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_IC = 1'b0,
    ARB_OWNER_DC = 1'b1
  } arb_owner_e;

  function automatic logic [31:0] arb_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ama_riscv_rr_arb2.sv
// rtl/ama_riscv_rr_arb2.sv - two-input round-robin picker; req[0]/gnt[0] is the icache, req[1]/gnt[1] the dcache
module ama_riscv_rr_arb2
  import ama_riscv_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  arb_owner_e last_grant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == ARB_OWNER_DC) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Starting at DC lets the icache win the first tie out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n)
      last_grant <= ARB_OWNER_DC;
    else if (advance && (gnt != 2'b00))
      last_grant <= gnt[1] ? ARB_OWNER_DC : ARB_OWNER_IC;
  end

endmodule

// File: rtl/ama_riscv_mem_arbiter.sv
// rtl/ama_riscv_mem_arbiter.sv - shares the main-memory line port between icache and dcache, one transaction in flight
// Defining AMA_RISCV_ARB_PERF_CNT_EN adds perf_clr and saturating grant/conflict counters.
module ama_riscv_mem_arbiter
  import ama_riscv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W_DFLT,
  parameter int LINE_W = ARB_LINE_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_rsp_valid,
  output logic [LINE_W-1:0] ic_rsp_data,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_we,
  input  logic [LINE_W-1:0] dc_req_wdata,
  output logic              dc_rsp_valid,
  output logic [LINE_W-1:0] dc_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
`ifdef AMA_RISCV_ARB_PERF_CNT_EN
  input  logic              perf_clr,
  output logic [31:0]       ic_grant_cnt,
  output logic [31:0]       dc_grant_cnt,
  output logic [31:0]       conflict_cnt,
`endif
  output logic              protocol_err
);

  arb_state_e        state, state_nxt;
  arb_owner_e        owner;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [LINE_W-1:0] wdata_q;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              accept;

  // Requests are masked during reset so no ready can leak out before the first edge.
  assign req    = rst_n ? {dc_req_valid, ic_req_valid} : 2'b00;
  assign accept = (state == ARB_IDLE) && (gnt != 2'b00);

  ama_riscv_rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (accept),
    .gnt     (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ARB_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    ic_req_ready  = 1'b0;
    dc_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    ic_rsp_valid  = 1'b0;
    dc_rsp_valid  = 1'b0;
    case (state)
      ARB_IDLE: begin
        ic_req_ready = gnt[0];
        dc_req_ready = gnt[1];
        if (accept)
          state_nxt = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready)
          state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_rsp_valid) begin
          ic_rsp_valid = (owner == ARB_OWNER_IC);
          dc_rsp_valid = (owner == ARB_OWNER_DC);
          state_nxt    = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner   <= ARB_OWNER_IC;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      if (gnt[1]) begin
        owner   <= ARB_OWNER_DC;
        addr_q  <= dc_req_addr;
        we_q    <= dc_req_we;
        wdata_q <= dc_req_wdata;
      end else begin
        owner   <= ARB_OWNER_IC;
        addr_q  <= ic_req_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      protocol_err <= 1'b0;
    else if (mem_rsp_valid && (state != ARB_WAIT))
      protocol_err <= 1'b1;
  end

  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;
  assign ic_rsp_data   = ic_rsp_valid ? mem_rsp_data : '0;
  assign dc_rsp_data   = dc_rsp_valid ? mem_rsp_data : '0;

`ifdef AMA_RISCV_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      ic_grant_cnt <= '0;
      dc_grant_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      if (accept && gnt[0])
        ic_grant_cnt <= arb_sat_inc(ic_grant_cnt);
      if (accept && gnt[1])
        dc_grant_cnt <= arb_sat_inc(dc_grant_cnt);
      if ((state == ARB_IDLE) && ic_req_valid && dc_req_valid)
        conflict_cnt <= arb_sat_inc(conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// tb/tb_ama_riscv_mem_arbiter.sv - self-checking bench for ama_riscv_mem_arbiter (AMA_RISCV_ARB_PERF_CNT_EN optional)
module tb_ama_riscv_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_req_valid, ic_req_ready, ic_rsp_valid;
  logic [AW-1:0] ic_req_addr;
  logic [LW-1:0] ic_rsp_data;
  logic          dc_req_valid, dc_req_ready, dc_req_we, dc_rsp_valid;
  logic [AW-1:0] dc_req_addr;
  logic [LW-1:0] dc_req_wdata, dc_rsp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata, mem_rsp_data;
  logic          protocol_err;
`ifdef AMA_RISCV_ARB_PERF_CNT_EN
  logic          perf_clr;
  logic [31:0]   ic_grant_cnt, dc_grant_cnt, conflict_cnt;
`endif

  always #5 clk = ~clk;

  ama_riscv_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ic_req_valid  (ic_req_valid),
    .ic_req_ready  (ic_req_ready),
    .ic_req_addr   (ic_req_addr),
    .ic_rsp_valid  (ic_rsp_valid),
    .ic_rsp_data   (ic_rsp_data),
    .dc_req_valid  (dc_req_valid),
    .dc_req_ready  (dc_req_ready),
    .dc_req_addr   (dc_req_addr),
    .dc_req_we     (dc_req_we),
    .dc_req_wdata  (dc_req_wdata),
    .dc_rsp_valid  (dc_rsp_valid),
    .dc_rsp_data   (dc_rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_we    (mem_req_we),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
`ifdef AMA_RISCV_ARB_PERF_CNT_EN
    .perf_clr      (perf_clr),
    .ic_grant_cnt  (ic_grant_cnt),
    .dc_grant_cnt  (dc_grant_cnt),
    .conflict_cnt  (conflict_cnt),
`endif
    .protocol_err  (protocol_err)
  );

  typedef struct {
    bit          icv;
    bit          dcv;
    logic [31:0] ia;
    logic [31:0] da;
    bit          dwe;
    logic [7:0]  wpat;
    int          rdly;
    int          wdly;
    logic [7:0]  rpat;
    int          exp_own;   // -1 none, 0 icache, 1 dcache
    logic [31:0] exp_addr;
    bit          exp_we;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   last_own;
  vec_t tbl [10];
  vec_t v;
  int   own;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_addr = '0; dc_req_we = 1'b0; dc_req_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
`ifdef AMA_RISCV_ARB_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_own = 1;
  endtask

  // One full transaction: accept cycle, rdly stalled issue cycles, wdly idle wait cycles, then the response.
  task automatic run_txn(input vec_t t, input logic [LW-1:0] wd, input logic [LW-1:0] rd);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_req_ready = 1'b0;
    ic_req_valid = t.icv; ic_req_addr = t.ia;
    dc_req_valid = t.dcv; dc_req_addr = t.da; dc_req_we = t.dwe; dc_req_wdata = wd;
    @(negedge clk);
    chk("ic_req_ready_accept", ic_req_ready, t.exp_own == 0);
    chk("dc_req_ready_accept", dc_req_ready, t.exp_own == 1);
    if (t.exp_own < 0) return;
    for (int c = 0; c <= t.rdly; c++) begin
      @(posedge clk); #1;
      mem_req_ready = (c == t.rdly);
      @(negedge clk);
      chk("mem_req_valid_issue", mem_req_valid, 1'b1);
      chk("mem_req_addr", mem_req_addr, t.exp_addr);
      chk("mem_req_we", mem_req_we, t.exp_we);
      if (t.exp_we) chk("mem_req_wdata", mem_req_wdata, wd);
      chk("busy_ready_zero", {ic_req_ready, dc_req_ready}, 2'b00);
    end
    for (int c = 0; c <= t.wdly; c++) begin
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = (c == t.wdly);
      mem_rsp_data  = (c == t.wdly) ? rd : '0;
      @(negedge clk);
      chk("mem_req_valid_wait", mem_req_valid, 1'b0);
      chk("ic_rsp_valid", ic_rsp_valid, (c == t.wdly) && (t.exp_own == 0));
      chk("dc_rsp_valid", dc_rsp_valid, (c == t.wdly) && (t.exp_own == 1));
      if (c == t.wdly) begin
        if (t.exp_own == 0) begin
          chk("ic_rsp_data", ic_rsp_data, rd);
          chk("dc_rsp_data_idle", dc_rsp_data, '0);
        end else begin
          if (!t.exp_we) chk("dc_rsp_data", dc_rsp_data, rd);
          chk("ic_rsp_data_idle", ic_rsp_data, '0);
        end
      end
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 8'h00, 0, 0, 8'h11,  0, 32'h100, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 8'h00, 0, 1, 8'h22,  1, 32'h200, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 8'h00, 1, 0, 8'h33,  0, 32'h100, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 8'h00, 0, 0, 8'h44,  1, 32'h200, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h040, 32'h000, 1'b0, 8'h00, 0, 0, 8'hA5,  0, 32'h040, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'h000, 32'h300, 1'b1, 8'h5A, 5, 1, 8'h00,  1, 32'h300, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 32'h440, 32'h480, 1'b0, 8'h00, 2, 3, 8'h66,  0, 32'h440, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 32'h000, 32'h500, 1'b0, 8'h00, 1, 0, 8'h77,  1, 32'h500, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 32'h700, 32'h740, 1'b0, 8'h00, 0, 0, 8'h00, -1, 32'h000, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 32'h600, 32'h640, 1'b1, 8'hC3, 0, 2, 8'h99,  0, 32'h600, 1'b0};

    do_reset();
    @(negedge clk);
    chk("rst_ready", {ic_req_ready, dc_req_ready}, 2'b00);
    chk("rst_rsp_valid", {ic_rsp_valid, dc_rsp_valid}, 2'b00);
    chk("rst_mem_req", {mem_req_valid, mem_req_we}, 2'b00);
    chk("rst_mem_req_addr", mem_req_addr, '0);
    chk("rst_mem_req_wdata", mem_req_wdata, '0);
    chk("rst_rsp_data", ic_rsp_data | dc_rsp_data, '0);
    chk("rst_protocol_err", protocol_err, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], {64{tbl[i].wpat}}, {64{tbl[i].rpat}});
`ifdef AMA_RISCV_ARB_PERF_CNT_EN
      if (i == 3) begin
        chk("ic_grant_cnt", ic_grant_cnt, 32'd2);
        chk("dc_grant_cnt", dc_grant_cnt, 32'd2);
        chk("conflict_cnt", conflict_cnt, 32'd4);
      end
`endif
    end

    // Reference model: single-valid wins outright; on a tie the one not granted last wins.
    last_own = 0;
    for (int n = 0; n < 40; n++) begin
      v.icv  = 1'($urandom_range(0, 1));
      v.dcv  = 1'($urandom_range(0, 1));
      v.ia   = $urandom & 32'hFFFF_FFC0;
      v.da   = $urandom & 32'hFFFF_FFC0;
      v.dwe  = 1'($urandom_range(0, 1));
      v.rdly = $urandom_range(0, 3);
      v.wdly = $urandom_range(0, 3);
      if (v.icv && v.dcv) own = (last_own == 1) ? 0 : 1;
      else if (v.icv)     own = 0;
      else if (v.dcv)     own = 1;
      else                own = -1;
      v.exp_own  = own;
      v.exp_addr = (own == 1) ? v.da : v.ia;
      v.exp_we   = (own == 1) && v.dwe;
      if (own >= 0) last_own = own;
      run_txn(v, rand_line(), rand_line());
    end

    // Stray memory response while idle.
    @(posedge clk); #1;
    ic_req_valid = 1'b0; dc_req_valid = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    @(negedge clk);
    chk("perr_before", protocol_err, 1'b0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1; mem_rsp_data = {16{32'hDEAD_BEEF}};
    @(negedge clk);
    chk("perr_no_route", {ic_rsp_valid, dc_rsp_valid}, 2'b00);
    chk("perr_no_data", ic_rsp_data | dc_rsp_data, '0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    @(negedge clk);
    chk("perr_set", protocol_err, 1'b1);
    v = '{1'b0, 1'b1, 32'h0, 32'h900, 1'b0, 8'h00, 0, 0, 8'h3C, 1, 32'h900, 1'b0};
    run_txn(v, '0, {64{8'h3C}});
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; dc_req_valid = 1'b0;
    @(negedge clk);
    chk("perr_sticky", protocol_err, 1'b1);
    do_reset();
    @(negedge clk);
    chk("perr_cleared", protocol_err, 1'b0);

    // Reset while a request is being issued.
    @(posedge clk); #1;
    ic_req_valid = 1'b1; ic_req_addr = 32'h800;
    @(negedge clk);
    chk("midrst_grant", ic_req_ready, 1'b1);
    @(posedge clk); #1;
    ic_req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_issue", mem_req_valid, 1'b1);
    chk("midrst_addr", mem_req_addr, 32'h800);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_dropped", mem_req_valid, 1'b0);
    chk("midrst_addr_clr", mem_req_addr, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ama_riscv_mem_arbiter.md
Name: ama_riscv_mem_arbiter

Overview:
- Shares the single main-memory line port between the icache miss path and the dcache miss/writeback path.
- Two requesters, one transaction in flight, round-robin on conflict.
- Sits between the caches (present when USE_CACHES is defined) and the main memory model inside ama_riscv_core_top.

Parameters:
- ADDR_W, 32, byte address width of requests.
- LINE_W, 512, cache-line data width (bits).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- ic_req_valid  in  1  icache line read request.
- ic_req_ready  out  1  icache request accepted this cycle.
- ic_req_addr  in  ADDR_W  icache line address.
- ic_rsp_valid  out  1  icache response data valid (1 cycle).
- ic_rsp_data  out  LINE_W  icache response line.
- dc_req_valid  in  1  dcache request.
- dc_req_ready  out  1  dcache request accepted this cycle.
- dc_req_addr  in  ADDR_W  dcache line address.
- dc_req_we  in  1  1 = writeback, 0 = line fill.
- dc_req_wdata  in  LINE_W  writeback line.
- dc_rsp_valid  out  1  dcache response valid (fill data or write ack).
- dc_rsp_data  out  LINE_W  dcache fill line.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  latched address.
- mem_req_we  out  1  latched write enable (0 for icache).
- mem_req_wdata  out  LINE_W  latched write data.
- mem_rsp_valid  in  1  memory response (read data or write ack).
- mem_rsp_data  in  LINE_W  memory read data.
- protocol_err  out  1  sticky flag: mem_rsp_valid seen outside ARB_WAIT.

Behaviour:
- Reset values: all *_ready, *_rsp_valid, mem_req_valid, mem_req_we and protocol_err are 0; data/addr outputs are 0; state is ARB_IDLE; last_grant is DC, so IC wins the first tie.
- States:
  - ARB_IDLE: if any req_valid, the arbiter picks a winner. Only one valid: that requester wins. Both valid: the requester not equal to last_grant wins. The winner's ready is asserted combinationally in the same cycle, and the loser's ready stays 0. On the edge it latches owner, addr, we (0 for IC), wdata; sets last_grant=owner; moves to ARB_ISSUE.
  - ARB_ISSUE: mem_req_valid=1 with latched fields, stable until mem_req_ready. Handshake (valid&&ready) moves to ARB_WAIT.
  - ARB_WAIT: on mem_rsp_valid, the response is routed combinationally to the owner (owner rsp_valid=1, rsp_data=mem_rsp_data) and the state returns to ARB_IDLE. The non-owner rsp_valid stays 0. Write acks assert dc_rsp_valid; dc_rsp_data is don't-care.
- Minimum latency: request accepted at cycle T → mem_req_valid at T+1 → if ready, ARB_WAIT at T+2 → response to requester in the same cycle as mem_rsp_valid (earliest T+2).
- No new request is accepted before return to ARB_IDLE. Back-to-back spacing is 3 cycles minimum.
- Requesters must hold valid/addr/data until ready. Deasserting valid before ready is legal (request withdrawn, no grant).
- mem_rsp_valid in ARB_IDLE or ARB_ISSUE is ignored for routing and sets protocol_err=1 until reset.
- Reset mid-transaction: returns to ARB_IDLE immediately and drops mem_req_valid; memory must be reset concurrently.
- rsp_data outputs are 0 when the corresponding rsp_valid=0.

Optional Feature:
- AMA_RISCV_ARB_PERF_CNT_EN defined: adds outputs ic_grant_cnt, dc_grant_cnt, conflict_cnt (32 bits each, saturating at 0xFFFF_FFFF, reset to 0).
  - Grant counters increment on each accepted request.
  - conflict_cnt increments each ARB_IDLE cycle with both req_valid=1.
  - Counters also clear synchronously on input perf_clr (present only with macro).
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines package: arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT}, arb_owner_e {ARB_OWNER_IC, ARB_OWNER_DC}, LINE_W default constant.
- Sub-module: ama_riscv_rr_arb2, a 2-input round-robin picker holding last_grant. Inputs req[1:0] and advance; output gnt[1:0].

Test Plan:
- IC only, addr 0x0000_0040, mem ready same cycle, rsp 2 cycles later with 0xA5..A5 → ic_req_ready at T, mem_req_addr 0x40 at T+1, ic_rsp_data 0xA5..A5, dc_rsp_valid stays 0.
- Both valid from reset, IC 0x100 and DC 0x200 → IC granted first; DC granted in next ARB_IDLE; mem_req_addr sequence 0x100, 0x200.
- Both continuously valid for 4 transactions → grant order IC, DC, IC, DC.
- DC writeback 0x300 with wdata pattern, mem_req_ready held low 5 cycles → mem_req_valid/addr/we=1/wdata stable for all 5 cycles; dc_rsp_valid on ack.
- mem_rsp_valid pulsed in ARB_IDLE → protocol_err=1 and remains set; no rsp_valid to either cache; cleared only by rst_n=0.
- With AMA_RISCV_ARB_PERF_CNT_EN, run the scenario 3 sequence → ic_grant_cnt=2, dc_grant_cnt=2, conflict_cnt=4.
